handshake_system: RTL and testbench
===================================

Name: handshake_system

Overview:
- Two cooperating Moore FSMs joined by an internal four-phase req/ack handshake.
- Front-end (master) FSM: while `request` is high and `confirm` is asserted, captures `data_in` into `first_data_out`, then forwards it over the internal handshake.
- Back-end (slave) FSM: captures the forwarded value into `second_data_out`.
- Used as a small data-transfer/handshake demonstrator between a host and a downstream consumer.

Parameters:
- DATA_W, 4, width of `data_in`, `first_data_out` and `second_data_out`.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- request  input  1  host session enable; level-sensitive
- confirm  input  1  `data_in` valid strobe; sampled only in M_WAIT
- data_in  input  DATA_W  host data
- first_data_out  output  DATA_W  register holding last value captured by master
- second_data_out  output  DATA_W  register holding last value delivered to slave

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - master goes to M_IDLE, slave goes to S_IDLE
  - internal req=0, ack=0
  - first_data_out=0, second_data_out=0
- Reset release takes effect from the next rising edge.
- Master states (internal req = 1 only in M_SEND):
  - M_IDLE: request=1 -> M_WAIT; else stay.
  - M_WAIT:
    - request=0 -> M_IDLE (priority over confirm).
    - else confirm=1 -> first_data_out<=data_in, go M_SEND.
    - else stay.
  - M_SEND: ack=1 -> M_RELEASE; else stay.
  - M_RELEASE: ack=0 -> (request=1 ? M_WAIT : M_IDLE); else stay.
- Slave states (ack = 1 only in S_ACK):
  - S_IDLE: req=1 -> second_data_out<=first_data_out, go S_ACK.
  - S_ACK: req=0 -> S_IDLE.
- Timing: confirm sampled high at edge k (master in M_WAIT):
  - edge k: first_data_out updated, req=1
  - edge k+1: second_data_out updated, ack=1
  - edge k+2: req=0
  - edge k+3: ack=0
  - edge k+4: master back in M_WAIT/M_IDLE
  - Latency data_in -> second_data_out: 2 edges.
  - Transfer cycle: 4 edges; earliest next capture at edge k+5.
- confirm held high continuously:
  - one capture per completed handshake cycle (every 5 edges).
  - data_in changes mid-handshake are ignored until the next M_WAIT capture.
- request dropping while master is in M_SEND/M_RELEASE does not abort; the transfer completes, then master goes to M_IDLE.
- Outputs hold their values indefinitely between captures and are never cleared except by reset.
- confirm/request unknown before first drive: only confirm in M_WAIT and request in M_IDLE/M_WAIT/M_RELEASE affect state.
- All registers are flip-flops; no combinational path from inputs to outputs.
- State encodings are implementation choice; unused encodings recover to M_IDLE/S_IDLE.

Optional Feature:
- Macro HANDSHAKE_BUSY_EN.
- Defined: adds output port `busy` (1 bit, registered-equivalent, derived from state). busy=1 whenever master is in M_SEND or M_RELEASE, or slave is in S_ACK; 0 after reset.
- Undefined: no `busy` port; all other behaviour identical.

Test Plan:
- Reset: assert reset_n=0 mid-run with outputs nonzero -> first_data_out=0 and second_data_out=0 immediately; both FSMs idle.
- Basic transfer: request=1, then confirm=1 with data_in=4'b0110 -> first_data_out=0110 at capture edge k; second_data_out=0110 at edge k+1.
- Held confirm with data change: after the first transfer, data_in=4'b0111 with confirm still 1 -> next capture at edge k+5 gives first_data_out=0111, then second_data_out=0111 one edge later; no capture during edges k+1..k+4.
- Request drop mid-transfer: deassert request during M_SEND -> handshake completes, second_data_out updated, master ends in M_IDLE; no further captures while request=0 even with confirm=1.
- Request priority in M_WAIT: request=0 and confirm=1 on the same edge -> no capture, master goes to M_IDLE, outputs unchanged.
- With HANDSHAKE_BUSY_EN defined: busy rises at capture edge k, stays high through edge k+3, and is low at edge k+4.

Source files
------------

// File: rtl/handshake_system.sv
// Master/slave Moore FSM pair joined by an internal four-phase req/ack handshake.
// Optional `busy` status output is enabled by defining HANDSHAKE_BUSY_EN.
module handshake_system #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              request,
  input  logic              confirm,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] first_data_out,
  output logic [DATA_W-1:0] second_data_out
`ifdef HANDSHAKE_BUSY_EN
  ,
  output logic              busy
`endif
);

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_WAIT    = 2'd1,
    M_SEND    = 2'd2,
    M_RELEASE = 2'd3
  } m_state_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } s_state_t;

  m_state_t m_state;
  s_state_t s_state;
  logic     req;
  logic     ack;

  // Master: captures host data on confirm and holds req until the slave acknowledges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state        <= M_IDLE;
      req            <= 1'b0;
      first_data_out <= '0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (request) m_state <= M_WAIT;
        end
        M_WAIT: begin
          if (!request) begin
            m_state <= M_IDLE;
          end else if (confirm) begin
            first_data_out <= data_in;
            req            <= 1'b1;
            m_state        <= M_SEND;
          end
        end
        M_SEND: begin
          if (ack) begin
            req     <= 1'b0;
            m_state <= M_RELEASE;
          end
        end
        M_RELEASE: begin
          // Transfer is never aborted; request only decides where we land afterwards.
          if (!ack) m_state <= request ? M_WAIT : M_IDLE;
        end
        default: begin
          req     <= 1'b0;
          m_state <= M_IDLE;
        end
      endcase
    end
  end

  // Slave: latches the forwarded value on req rise and acknowledges until req falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_state         <= S_IDLE;
      ack             <= 1'b0;
      second_data_out <= '0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (req) begin
            second_data_out <= first_data_out;
            ack             <= 1'b1;
            s_state         <= S_ACK;
          end
        end
        S_ACK: begin
          if (!req) begin
            ack     <= 1'b0;
            s_state <= S_IDLE;
          end
        end
        default: begin
          ack     <= 1'b0;
          s_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef HANDSHAKE_BUSY_EN
  assign busy = (m_state == M_SEND) || (m_state == M_RELEASE) || (s_state == S_ACK);
`endif

endmodule

// File: tb/tb_handshake_system.sv
// Directed self-checking bench for handshake_system (optionally with HANDSHAKE_BUSY_EN).
module tb_handshake_system;

  logic       clock;
  logic       reset_n;
  logic       request;
  logic       confirm;
  logic [3:0] data_in;
  logic [3:0] first_data_out;
  logic [3:0] second_data_out;
`ifdef HANDSHAKE_BUSY_EN
  logic       busy;
`endif

  int checks;
  int failures;

  handshake_system #(.DATA_W(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .request        (request),
    .confirm        (confirm),
    .data_in        (data_in),
    .first_data_out (first_data_out),
    .second_data_out(second_data_out)
`ifdef HANDSHAKE_BUSY_EN
    ,
    .busy           (busy)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_out(input int n);
    request = 1'b0;
    confirm = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    request = 1'b0;
    confirm = 1'b0;
    data_in = 4'b0000;
    #3;
    checks++;
    if (first_data_out !== 4'b0000) begin
      $display("FAIL reset_first got=%b exp=0000", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b0000) begin
      $display("FAIL reset_second got=%b exp=0000", second_data_out); failures++;
    end
`ifdef HANDSHAKE_BUSY_EN
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got=%b exp=0", busy); failures++;
    end
`endif
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_and_held_confirm();
    request = 1'b1;
    tick();
    confirm = 1'b1;
    data_in = 4'b0110;
    tick();  // edge k
    checks++;
    if (first_data_out !== 4'b0110) begin
      $display("FAIL basic_first_k got=%b exp=0110", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b0000) begin
      $display("FAIL basic_second_k got=%b exp=0000", second_data_out); failures++;
    end
`ifdef HANDSHAKE_BUSY_EN
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_k got=%b exp=1", busy); failures++;
    end
`endif
    data_in = 4'b0111;
    tick();  // edge k+1
    checks++;
    if (second_data_out !== 4'b0110) begin
      $display("FAIL basic_second_k1 got=%b exp=0110", second_data_out); failures++;
    end
    for (int e = 1; e <= 4; e++) begin
      if (e > 1) tick();
      checks++;
      if (first_data_out !== 4'b0110) begin
        $display("FAIL held_no_capture edge=k+%0d got=%b exp=0110", e, first_data_out); failures++;
      end
`ifdef HANDSHAKE_BUSY_EN
      checks++;
      if (busy !== (e < 4)) begin
        $display("FAIL busy_k%0d got=%b exp=%b", e, busy, (e < 4)); failures++;
      end
`endif
    end
    tick();  // edge k+5
    checks++;
    if (first_data_out !== 4'b0111) begin
      $display("FAIL held_first_k5 got=%b exp=0111", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b0110) begin
      $display("FAIL held_second_k5 got=%b exp=0110", second_data_out); failures++;
    end
    tick();  // edge k+6
    checks++;
    if (second_data_out !== 4'b0111) begin
      $display("FAIL held_second_k6 got=%b exp=0111", second_data_out); failures++;
    end
    idle_out(6);
  endtask

  task automatic test_request_drop();
    request = 1'b1;
    confirm = 1'b0;
    tick();
    confirm = 1'b1;
    data_in = 4'b1001;
    tick();  // edge k, master in M_SEND
    request = 1'b0;
    confirm = 1'b0;
    tick();  // edge k+1
    checks++;
    if (second_data_out !== 4'b1001) begin
      $display("FAIL drop_second got=%b exp=1001", second_data_out); failures++;
    end
    tick();
    tick();
    tick();  // edge k+4, master should be idle
    confirm = 1'b1;
    data_in = 4'b1111;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (first_data_out !== 4'b1001) begin
      $display("FAIL drop_no_capture got=%b exp=1001", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b1001) begin
      $display("FAIL drop_second_hold got=%b exp=1001", second_data_out); failures++;
    end
    request = 1'b1;
    data_in = 4'b0011;
    tick();  // idle -> wait, no capture yet
    checks++;
    if (first_data_out !== 4'b1001) begin
      $display("FAIL drop_idle_proof got=%b exp=1001", first_data_out); failures++;
    end
    tick();
    checks++;
    if (first_data_out !== 4'b0011) begin
      $display("FAIL drop_recapture got=%b exp=0011", first_data_out); failures++;
    end
    idle_out(6);
  endtask

  task automatic test_request_priority();
    request = 1'b1;
    confirm = 1'b0;
    tick();  // master in M_WAIT
    request = 1'b0;
    confirm = 1'b1;
    data_in = 4'b0101;
    tick();
    checks++;
    if (first_data_out !== 4'b0011) begin
      $display("FAIL prio_no_capture got=%b exp=0011", first_data_out); failures++;
    end
    request = 1'b1;
    tick();  // idle -> wait
    checks++;
    if (first_data_out !== 4'b0011) begin
      $display("FAIL prio_idle_proof got=%b exp=0011", first_data_out); failures++;
    end
    tick();
    checks++;
    if (first_data_out !== 4'b0101) begin
      $display("FAIL prio_capture got=%b exp=0101", first_data_out); failures++;
    end
  endtask

  task automatic test_reset_midrun();
    // Handshake from the previous task is in flight: master in M_SEND.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (first_data_out !== 4'b0000) begin
      $display("FAIL midreset_first got=%b exp=0000", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b0000) begin
      $display("FAIL midreset_second got=%b exp=0000", second_data_out); failures++;
    end
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    request = 1'b1;
    confirm = 1'b1;
    data_in = 4'b1100;
    tick();  // idle -> wait
    checks++;
    if (first_data_out !== 4'b0000) begin
      $display("FAIL midreset_idle_first got=%b exp=0000", first_data_out); failures++;
    end
    checks++;
    if (second_data_out !== 4'b0000) begin
      $display("FAIL midreset_idle_second got=%b exp=0000", second_data_out); failures++;
    end
    tick();
    checks++;
    if (first_data_out !== 4'b1100) begin
      $display("FAIL midreset_capture got=%b exp=1100", first_data_out); failures++;
    end
    tick();
    checks++;
    if (second_data_out !== 4'b1100) begin
      $display("FAIL midreset_deliver got=%b exp=1100", second_data_out); failures++;
    end
    idle_out(6);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_and_held_confirm();
    test_request_drop();
    test_request_priority();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
